// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - control bundle type, ALUOp codes and bubble constant
package ctrl_pkg;

    localparam int RD_W = 5;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10
    } alu_op_t;

    typedef struct packed {
        alu_op_t         alu_op;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic            mem_read;
        logic            mem_write;
        logic            mem_2_reg;
        logic            reg_write;
        logic [RD_W-1:0] rd;
    } ctrl_bundle_t;

    // A bubble must never touch memory or the register file.
    localparam ctrl_bundle_t CTRL_BUBBLE = '{
        alu_op:    ALU_ADD,
        alu_src:   1'b0,
        branch:    1'b0,
        jump:      1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        mem_2_reg: 1'b0,
        reg_write: 1'b0,
        rd:        '0
    };

endpackage

// File: rtl/ctrl_stage_reg.sv
// rtl/ctrl_stage_reg.sv - one control pipeline register with hold and bubble insert
module ctrl_stage_reg
    import ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  ctrl_bundle_t d,
    output ctrl_bundle_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= CTRL_BUBBLE;
        end else if (en) begin
            q <= clr ? CTRL_BUBBLE : d;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX, EX/MEM, MEM/WB control pipeline with load-use and flush handling
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = RD_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_alu_src,
    input  logic                  id_branch,
    input  logic                  id_jump,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_2_reg,
    input  logic                  id_reg_write,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_taken,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_2_reg,
    output logic                  ex_reg_write,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_mem_2_reg,
    output logic                  mem_reg_write,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_mem_2_reg,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  stall,
    output logic                  flush_if_id,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    ctrl_bundle_t id_b, ex_q, mem_q, wb_q;
    logic         load_use;
    logic         unused_fields;

    // Writes to x0 are dropped at entry so later stages never see them.
    always_comb begin
        id_b           = CTRL_BUBBLE;
        id_b.alu_op    = alu_op_t'(id_alu_op);
        id_b.alu_src   = id_alu_src;
        id_b.branch    = id_branch;
        id_b.jump      = id_jump;
        id_b.mem_read  = id_mem_read;
        id_b.mem_write = id_mem_write;
        id_b.mem_2_reg = id_mem_2_reg;
        id_b.reg_write = id_reg_write && (id_rd != '0);
        id_b.rd        = id_rd;
    end

    assign load_use    = ex_q.mem_read && (ex_q.rd != '0)
                         && ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
    assign stall       = load_use && !ex_taken;
    assign flush_if_id = ex_taken;

    ctrl_stage_reg u_id_ex  (.clk(clk), .rst(rst), .en(en), .clr(ex_taken || load_use), .d(id_b),  .q(ex_q));
    ctrl_stage_reg u_ex_mem (.clk(clk), .rst(rst), .en(en), .clr(1'b0),                 .d(ex_q),  .q(mem_q));
    ctrl_stage_reg u_mem_wb (.clk(clk), .rst(rst), .en(en), .clr(1'b0),                 .d(mem_q), .q(wb_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (en) begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ex_taken && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign ex_alu_op     = ex_q.alu_op;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_branch     = ex_q.branch;
    assign ex_jump       = ex_q.jump;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_2_reg  = ex_q.mem_2_reg;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_rd         = ex_q.rd;
    assign mem_mem_read  = mem_q.mem_read;
    assign mem_mem_write = mem_q.mem_write;
    assign mem_mem_2_reg = mem_q.mem_2_reg;
    assign mem_reg_write = mem_q.reg_write;
    assign mem_rd        = mem_q.rd;
    assign wb_mem_2_reg  = wb_q.mem_2_reg;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_rd         = wb_q.rd;

    // Later stages carry the full bundle but only expose the fields consumed downstream.
    assign unused_fields = ^{mem_q.alu_op, mem_q.alu_src, mem_q.branch, mem_q.jump,
                             wb_q.alu_op, wb_q.alu_src, wb_q.branch, wb_q.jump,
                             wb_q.mem_read, wb_q.mem_write};

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - scoreboard bench for ctrl_pipe with directed and random stimulus
module tb_ctrl_pipe;

    typedef struct {
        logic       rst, en, taken;
        logic [1:0] alu_op;
        logic       alu_src, branch, jump, mem_read, mem_write, mem_2_reg, reg_write;
        logic [4:0] rs1, rs2, rd;
    } stim_t;

    typedef struct {
        logic [1:0] alu_op;
        logic       alu_src, branch, jump, mem_read, mem_write, mem_2_reg, reg_write;
        logic [4:0] rd;
    } bun_t;

    typedef struct {
        bun_t ex, mem, wb;
        logic stall, flush;
        int   scnt, fcnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, ex_taken;
    logic [1:0] id_alu_op;
    logic       id_alu_src, id_branch, id_jump, id_mem_read, id_mem_write, id_mem_2_reg, id_reg_write;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic [1:0]  a_ex_alu_op, b_ex_alu_op;
    logic        a_ex_alu_src, a_ex_branch, a_ex_jump, a_ex_mem_read, a_ex_mem_write, a_ex_mem_2_reg, a_ex_reg_write;
    logic        b_ex_alu_src, b_ex_branch, b_ex_jump, b_ex_mem_read, b_ex_mem_write, b_ex_mem_2_reg, b_ex_reg_write;
    logic [4:0]  a_ex_rd, a_mem_rd, a_wb_rd, b_ex_rd, b_mem_rd, b_wb_rd;
    logic        a_mem_mem_read, a_mem_mem_write, a_mem_mem_2_reg, a_mem_reg_write, a_wb_mem_2_reg, a_wb_reg_write;
    logic        b_mem_mem_read, b_mem_mem_write, b_mem_mem_2_reg, b_mem_reg_write, b_wb_mem_2_reg, b_wb_reg_write;
    logic        a_stall, a_flush, b_stall, b_flush;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic [1:0]  b_stall_cnt, b_flush_cnt;

    ctrl_pipe #(.REG_ADDR_W(5), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .en(en),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_2_reg(id_mem_2_reg),
        .id_reg_write(id_reg_write), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_taken(ex_taken),
        .ex_alu_op(a_ex_alu_op), .ex_alu_src(a_ex_alu_src), .ex_branch(a_ex_branch), .ex_jump(a_ex_jump),
        .ex_mem_read(a_ex_mem_read), .ex_mem_write(a_ex_mem_write), .ex_mem_2_reg(a_ex_mem_2_reg),
        .ex_reg_write(a_ex_reg_write), .ex_rd(a_ex_rd),
        .mem_mem_read(a_mem_mem_read), .mem_mem_write(a_mem_mem_write), .mem_mem_2_reg(a_mem_mem_2_reg),
        .mem_reg_write(a_mem_reg_write), .mem_rd(a_mem_rd),
        .wb_mem_2_reg(a_wb_mem_2_reg), .wb_reg_write(a_wb_reg_write), .wb_rd(a_wb_rd),
        .stall(a_stall), .flush_if_id(a_flush), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    ctrl_pipe #(.REG_ADDR_W(5), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_2_reg(id_mem_2_reg),
        .id_reg_write(id_reg_write), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_taken(ex_taken),
        .ex_alu_op(b_ex_alu_op), .ex_alu_src(b_ex_alu_src), .ex_branch(b_ex_branch), .ex_jump(b_ex_jump),
        .ex_mem_read(b_ex_mem_read), .ex_mem_write(b_ex_mem_write), .ex_mem_2_reg(b_ex_mem_2_reg),
        .ex_reg_write(b_ex_reg_write), .ex_rd(b_ex_rd),
        .mem_mem_read(b_mem_mem_read), .mem_mem_write(b_mem_mem_write), .mem_mem_2_reg(b_mem_mem_2_reg),
        .mem_reg_write(b_mem_reg_write), .mem_rd(b_mem_rd),
        .wb_mem_2_reg(b_wb_mem_2_reg), .wb_reg_write(b_wb_reg_write), .wb_rd(b_wb_rd),
        .stall(b_stall), .flush_if_id(b_flush), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    logic [13:0] a_ex_v, b_ex_v;
    logic [8:0]  a_mem_v, b_mem_v;
    logic [6:0]  a_wb_v, b_wb_v;
    assign a_ex_v  = {a_ex_alu_op, a_ex_alu_src, a_ex_branch, a_ex_jump, a_ex_mem_read,
                      a_ex_mem_write, a_ex_mem_2_reg, a_ex_reg_write, a_ex_rd};
    assign b_ex_v  = {b_ex_alu_op, b_ex_alu_src, b_ex_branch, b_ex_jump, b_ex_mem_read,
                      b_ex_mem_write, b_ex_mem_2_reg, b_ex_reg_write, b_ex_rd};
    assign a_mem_v = {a_mem_mem_read, a_mem_mem_write, a_mem_mem_2_reg, a_mem_reg_write, a_mem_rd};
    assign b_mem_v = {b_mem_mem_read, b_mem_mem_write, b_mem_mem_2_reg, b_mem_reg_write, b_mem_rd};
    assign a_wb_v  = {a_wb_mem_2_reg, a_wb_reg_write, a_wb_rd};
    assign b_wb_v  = {b_wb_mem_2_reg, b_wb_reg_write, b_wb_rd};

    function automatic logic [13:0] ex_pack(input bun_t b);
        return {b.alu_op, b.alu_src, b.branch, b.jump, b.mem_read, b.mem_write, b.mem_2_reg, b.reg_write, b.rd};
    endfunction
    function automatic logic [8:0] mem_pack(input bun_t b);
        return {b.mem_read, b.mem_write, b.mem_2_reg, b.reg_write, b.rd};
    endfunction
    function automatic logic [6:0] wb_pack(input bun_t b);
        return {b.mem_2_reg, b.reg_write, b.rd};
    endfunction

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    // Reference: three in-flight slots plus plain event counts.
    bun_t m_ex, m_mem, m_wb, nop_b;
    int   m_scnt, m_fcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall",         32'(a_stall),     32'(e.stall));
            check("flush_if_id",   32'(a_flush),     32'(e.flush));
            check("ex_bundle",     32'(a_ex_v),      32'(ex_pack(e.ex)));
            check("mem_bundle",    32'(a_mem_v),     32'(mem_pack(e.mem)));
            check("wb_bundle",     32'(a_wb_v),      32'(wb_pack(e.wb)));
            check("stall_cnt",     32'(a_stall_cnt), 32'(sat(e.scnt, 65535)));
            check("flush_cnt",     32'(a_flush_cnt), 32'(sat(e.fcnt, 65535)));
            check("w2_pipe",       32'({b_stall, b_flush, b_ex_v, b_mem_v, b_wb_v}),
                  32'({e.stall, e.flush, ex_pack(e.ex), mem_pack(e.mem), wb_pack(e.wb)}));
            check("w2_stall_cnt",  32'(b_stall_cnt), 32'(sat(e.scnt, 3)));
            check("w2_flush_cnt",  32'(b_flush_cnt), 32'(sat(e.fcnt, 3)));
        end
    end

    function automatic stim_t nop();
        stim_t s;
        s = '{rst: 1'b0, en: 1'b1, taken: 1'b0, alu_op: 2'b00, alu_src: 1'b0, branch: 1'b0,
              jump: 1'b0, mem_read: 1'b0, mem_write: 1'b0, mem_2_reg: 1'b0, reg_write: 1'b0,
              rs1: 5'd0, rs2: 5'd0, rd: 5'd0};
        return s;
    endfunction

    function automatic stim_t load(input logic [4:0] rd);
        stim_t s = nop();
        s.mem_read = 1'b1; s.mem_2_reg = 1'b1; s.reg_write = 1'b1; s.alu_src = 1'b1; s.rd = rd;
        return s;
    endfunction

    function automatic stim_t rtype(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        stim_t s = nop();
        s.alu_op = 2'b10; s.reg_write = 1'b1; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        rst = s.rst; en = s.en; ex_taken = s.taken;
        id_alu_op = s.alu_op; id_alu_src = s.alu_src; id_branch = s.branch; id_jump = s.jump;
        id_mem_read = s.mem_read; id_mem_write = s.mem_write; id_mem_2_reg = s.mem_2_reg;
        id_reg_write = s.reg_write; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
    endtask

    // Called just after a rising edge: applies inputs, predicts this cycle, advances the model.
    task automatic step(input stim_t s);
        exp_t e;
        bun_t nb;
        logic lu;
        drive(s);
        lu = m_ex.mem_read && (m_ex.rd != 0) && ((m_ex.rd == s.rs1) || (m_ex.rd == s.rs2));
        e.ex = m_ex; e.mem = m_mem; e.wb = m_wb;
        e.stall = lu && !s.taken;
        e.flush = s.taken;
        e.scnt = m_scnt; e.fcnt = m_fcnt;
        exp_q.push_back(e);
        nb = '{alu_op: s.alu_op, alu_src: s.alu_src, branch: s.branch, jump: s.jump,
               mem_read: s.mem_read, mem_write: s.mem_write, mem_2_reg: s.mem_2_reg,
               reg_write: s.reg_write && (s.rd != 0), rd: s.rd};
        if (s.rst) begin
            m_ex = nop_b; m_mem = nop_b; m_wb = nop_b; m_scnt = 0; m_fcnt = 0;
        end else if (s.en) begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (s.taken || lu) ? nop_b : nb;
            if (e.stall) m_scnt++;
            if (s.taken) m_fcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_t s;
        nop_b = '{alu_op: 2'b00, alu_src: 1'b0, branch: 1'b0, jump: 1'b0, mem_read: 1'b0,
                  mem_write: 1'b0, mem_2_reg: 1'b0, reg_write: 1'b0, rd: 5'd0};
        m_ex = nop_b; m_mem = nop_b; m_wb = nop_b; m_scnt = 0; m_fcnt = 0;
        s = nop(); s.rst = 1'b1; s.taken = 1'b1;
        drive(s);
        @(posedge clk);
        #1;

        // R-type flowing through all three stages
        step(rtype(5'd1, 5'd2, 5'd5));
        repeat (3) step(nop());

        // load-use on rs2, then the held instruction re-issues
        step(load(5'd7));
        step(rtype(5'd3, 5'd7, 5'd8));
        step(rtype(5'd3, 5'd7, 5'd8));
        repeat (2) step(nop());

        // load to x0 creates no hazard; write to x0 is suppressed
        step(load(5'd0));
        step(rtype(5'd0, 5'd4, 5'd0));
        repeat (2) step(nop());

        // branch taken beats load-use
        step(load(5'd9));
        s = rtype(5'd9, 5'd1, 5'd10); s.taken = 1'b1;
        step(s);
        repeat (2) step(nop());

        // freeze with hazard pending
        step(load(5'd3));
        s = rtype(5'd3, 5'd3, 5'd11); s.en = 1'b0;
        repeat (4) step(s);
        s.en = 1'b1;
        step(s);
        step(s);

        // back-to-back stalls saturate the narrow counter
        repeat (5) begin
            step(load(5'd4));
            step(rtype(5'd4, 5'd0, 5'd12));
        end
        repeat (4) begin
            s = nop(); s.taken = 1'b1;
            step(s);
        end

        // reset mid-stream
        step(load(5'd6));
        s = rtype(5'd6, 5'd6, 5'd2); s.rst = 1'b1; s.taken = 1'b1;
        step(s);
        step(nop());

        for (int i = 0; i < 1500; i++) begin
            s.rst       = ($urandom_range(0, 99) == 0);
            s.en        = ($urandom_range(0, 7) != 0);
            s.taken     = ($urandom_range(0, 5) == 0);
            s.alu_op    = 2'($urandom_range(0, 3));
            s.alu_src   = 1'($urandom);
            s.branch    = 1'($urandom);
            s.jump      = 1'($urandom);
            s.mem_read  = ($urandom_range(0, 2) == 0);
            s.mem_write = 1'($urandom);
            s.mem_2_reg = 1'($urandom);
            s.reg_write = 1'($urandom);
            s.rs1       = 5'($urandom_range(0, 7));
            s.rs2       = 5'($urandom_range(0, 7));
            s.rd        = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            step(s);
        end

        drive(nop());
        @(negedge clk);
        @(negedge clk);
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
